// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the one-hot ring counter.
// onehot() is used only when RING_COUNTER_SELF_CORRECT_EN is defined.
package ring_counter_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;
    localparam int unsigned WIDTH_MAX     = 32;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Hot bit starts at the end it travels away from.
    function automatic logic [WIDTH_MAX-1:0] reset_pattern(input int unsigned width,
                                                           input logic        shift_right);
        logic [WIDTH_MAX-1:0] pat;
        pat = '0;
        if (dir_e'(shift_right) == DIR_RIGHT) begin
            pat[width-1] = 1'b1;
        end else begin
            pat[0] = 1'b1;
        end
        return pat;
    endfunction

    function automatic logic onehot(input logic [WIDTH_MAX-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < WIDTH_MAX; i++) begin
            cnt += int'(vec[i]);
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/ring_counter_onehot_chk.sv
// Combinational one-hot detector over a WIDTH-bit vector.
// Instantiated by ring_counter only when RING_COUNTER_SELF_CORRECT_EN is defined.
module ring_counter_onehot_chk
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             onehot_o
);

    logic [WIDTH_MAX-1:0] vec_ext;

    always_comb begin
        vec_ext              = '0;
        vec_ext[WIDTH-1:0]   = vec_i;
        onehot_o             = onehot(vec_ext);
    end

endmodule

// File: rtl/ring_counter.sv
// One-hot ring counter: a single set bit rotates one position per clock.
// Optional macro RING_COUNTER_SELF_CORRECT_EN reloads the reset pattern from illegal states.
module ring_counter
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEFAULT,
    parameter logic        SHIFT_RIGHT = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH_MAX-1:0] RST_FULL = reset_pattern(WIDTH, SHIFT_RIGHT);
    localparam logic [WIDTH-1:0]     RST_PAT  = RST_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] rot;
    logic             legal;

`ifdef RING_COUNTER_SELF_CORRECT_EN
    ring_counter_onehot_chk #(
        .WIDTH (WIDTH)
    ) u_onehot_chk (
        .vec_i    (out_q),
        .onehot_o (legal)
    );
`else
    assign legal = 1'b1;
`endif

    always_comb begin
        rot = out_q;
        if (dir_e'(SHIFT_RIGHT) == DIR_RIGHT) begin
            rot = {out_q[0], out_q[WIDTH-1:1]};
        end else begin
            rot = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        end
        out_d = legal ? rot : RST_PAT;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            out_q <= RST_PAT;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_ring_counter.sv
// Self-checking bench for ring_counter: three configurations driven by one clear,
// compared against a position-index model.
module tb_ring_counter;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] out_r;
    logic [3:0] out_l;
    logic [7:0] out_w;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int          pos_r  = 0;
    int          pos_l  = 0;
    int          pos_w  = 0;

    always #5 clk = ~clk;

    ring_counter #(.WIDTH(4), .SHIFT_RIGHT(1'b1)) dut (
        .clk (clk), .clr (clr), .out (out_r)
    );
    ring_counter #(.WIDTH(4), .SHIFT_RIGHT(1'b0)) dut_l (
        .clk (clk), .clr (clr), .out (out_l)
    );
    ring_counter #(.WIDTH(8), .SHIFT_RIGHT(1'b1)) dut_w (
        .clk (clk), .clr (clr), .out (out_w)
    );

    // Expected value: bit index derived from how many steps since clear.
    function automatic logic [31:0] hot(input int w, input bit right, input int pos);
        return 32'd1 << (right ? (w - 1 - pos) : pos);
    endfunction

    task automatic step(input logic c);
        clr = c;
        @(posedge clk);
        if (c) begin
            pos_r = 0; pos_l = 0; pos_w = 0;
        end else begin
            pos_r = (pos_r + 1) % 4;
            pos_l = (pos_l + 1) % 4;
            pos_w = (pos_w + 1) % 8;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            checks++;
            if (out_r !== 4'b1000) $display("FAIL reset_r[%0d] got %b want 1000", i, out_r);
            else passed++;
            checks++;
            if (out_l !== 4'b0001) $display("FAIL reset_l[%0d] got %b want 0001", i, out_l);
            else passed++;
            e = 32'h80;
            checks++;
            if (out_w !== e[7:0]) $display("FAIL reset_w[%0d] got %b want %b", i, out_w, e[7:0]);
            else passed++;
        end
    endtask

    task automatic test_free_run();
        logic [31:0] er, el, ew;
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            er = hot(4, 1'b1, pos_r);
            el = hot(4, 1'b0, pos_l);
            ew = hot(8, 1'b1, pos_w);
            checks++;
            if (out_r !== er[3:0]) $display("FAIL run_r[%0d] got %b want %b", i, out_r, er[3:0]);
            else passed++;
            checks++;
            if (out_l !== el[3:0]) $display("FAIL run_l[%0d] got %b want %b", i, out_l, el[3:0]);
            else passed++;
            checks++;
            if (out_w !== ew[7:0]) $display("FAIL run_w[%0d] got %b want %b", i, out_w, ew[7:0]);
            else passed++;
        end
    endtask

    task automatic test_mid_clear();
        int budget;
        budget = 0;
        while (pos_r != 2 && budget < 8) begin
            step(1'b0);
            budget++;
        end
        checks++;
        if (out_r !== 4'b0010) $display("FAIL mid_reach got %b want 0010", out_r);
        else passed++;
        step(1'b1);
        checks++;
        if (out_r !== 4'b1000) $display("FAIL mid_clr got %b want 1000", out_r);
        else passed++;
        step(1'b0);
        checks++;
        if (out_r !== 4'b0100) $display("FAIL mid_after got %b want 0100", out_r);
        else passed++;
    endtask

    task automatic test_width8();
        step(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            checks++;
            if ($countones(out_w) != 1) $display("FAIL w8_onehot[%0d] got %b want one bit set", i, out_w);
            else passed++;
        end
        checks++;
        if (out_w !== 8'h80) $display("FAIL w8_wrap got %b want 10000000", out_w);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] er, el, ew;
        logic        c;
        for (int i = 0; i < 300; i++) begin
            c = ($urandom_range(0, 6) == 0);
            step(c);
            er = hot(4, 1'b1, pos_r);
            el = hot(4, 1'b0, pos_l);
            ew = hot(8, 1'b1, pos_w);
            checks++;
            if (out_r !== er[3:0] || out_l !== el[3:0] || out_w !== ew[7:0])
                $display("FAIL rand[%0d] clr=%b got %b/%b/%b want %b/%b/%b", i, c,
                         out_r, out_l, out_w, er[3:0], el[3:0], ew[7:0]);
            else passed++;
        end
    endtask

    task automatic test_self_correct();
        logic [3:0] want_zero;
        logic [3:0] want_0110;
`ifdef RING_COUNTER_SELF_CORRECT_EN
        want_zero = 4'b1000;
        want_0110 = 4'b1000;
`else
        want_zero = 4'b0000;
        want_0110 = 4'b0011;
`endif
        force dut.out_q = 4'b0000;
        #1 release dut.out_q;
        step(1'b0);
        checks++;
        if (out_r !== want_zero) $display("FAIL corr_zero got %b want %b", out_r, want_zero);
        else passed++;
        force dut.out_q = 4'b0110;
        #1 release dut.out_q;
        step(1'b0);
        checks++;
        if (out_r !== want_0110) $display("FAIL corr_0110 got %b want %b", out_r, want_0110);
        else passed++;
        step(1'b1);
        checks++;
        if (out_r !== 4'b1000) $display("FAIL corr_recover got %b want 1000", out_r);
        else passed++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_free_run();
        test_mid_clear();
        test_width8();
        test_random();
        test_self_correct();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
